pipeline_ctrl: RTL

//  Parametrised hazard/stall/flush controller for the 5-stage RV32I pipeline (IF/ID/EX/MA/WB).

---
 rtl/riscv_small_pkg.sv | 39 +++
 rtl/fwd_unit.sv | 34 +++
 rtl/pipeline_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_small_pkg.sv
// Shared encodings for the small RV32I core control path.
// ALU operand selects, next-PC type, forward select and controller states.
package riscv_small_pkg;

    typedef enum logic [1:0] {
        SRC1_PC     = 2'd0,
        SRC1_RS1    = 2'd1,
        SRC1_FWD_MA = 2'd2,
        SRC1_FWD_WB = 2'd3
    } ctrlAluSrc1_e;

    typedef enum logic [1:0] {
        SRC2_RS2    = 2'd0,
        SRC2_IMM    = 2'd1,
        SRC2_FWD_MA = 2'd2,
        SRC2_FWD_WB = 2'd3
    } ctrlAluSrc2_e;

    typedef enum logic [1:0] {
        PC_NEXT = 2'd0,
        PC_JUMP = 2'd1,
        PC_TRAP = 2'd2
    } nextPCType_e;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IMEM_WAIT = 2'd1,
        DMEM_WAIT = 2'd2,
        TRAP      = 2'd3
    } ctrlState_e;

    // Codes line up with the FWD_MA/FWD_WB values of both operand selects
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MA   = 2'd2,
        FWD_WB   = 2'd3
    } fwd_e;

endpackage

// File: rtl/fwd_unit.sv
// Forward select for one EX operand; a load hit in MA is reported
// as a load-use hazard instead of being forwarded.
module fwd_unit
    import riscv_small_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  use_rs,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rd_ma,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic                  wr_en_ma,
    input  logic                  wr_en_wb,
    input  logic                  load_ma,
    output logic [1:0]            fwd,
    output logic                  load_use
);

    logic hit_ma;
    logic hit_wb;

    always_comb begin
        hit_ma   = use_rs & wr_en_ma & (rd_ma != '0) & (rd_ma == rs_addr);
        hit_wb   = use_rs & wr_en_wb & (rd_wb != '0) & (rd_wb == rs_addr);
        load_use = hit_ma & load_ma;
        fwd      = FWD_NONE;
        if (hit_ma) begin
            fwd = load_ma ? FWD_NONE : FWD_MA;
        end else if (hit_wb) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall/flush/trap controller for the 5-stage pipeline.
// Define PIPELINE_CTRL_PERF_EN to add stall_cnt/flush_cnt counters.
module pipeline_ctrl
    import riscv_small_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    REG_ADDR_W  = 5,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0004,
    parameter int                    MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic [REG_ADDR_W-1:0] rs1_addr_ex,
    input  logic [REG_ADDR_W-1:0] rs2_addr_ex,
    input  logic [REG_ADDR_W-1:0] rd0_addr_ma,
    input  logic [REG_ADDR_W-1:0] rd0_addr_wb,
    input  logic                  rd0_wr_en_ma,
    input  logic                  rd0_wr_en_wb,
    input  logic                  data_rd_en_ma,
    input  logic                  data_wr_en_ma,
    input  logic                  alu_src1_ex,
    input  logic                  alu_src2_ex,
    input  logic                  branch_taken,
    input  logic                  exception,
    input  logic [DATA_WIDTH-1:0] pc_ex,
    input  logic                  inst_ready,
    input  logic                  data_ready,
    output logic [1:0]            alu_src1,
    output logic [1:0]            alu_src2,
    output logic [1:0]            pc_sel,
    output logic [DATA_WIDTH-1:0] trap_addr,
    output logic [DATA_WIDTH-1:0] epc,
    output logic                  inst_rd_en,
    output logic                  if_id_clk_en,
    output logic                  id_ex_clk_en,
    output logic                  ex_ma_clk_en,
    output logic                  ma_wb_clk_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_ma_flush,
    output logic                  mem_timeout
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [1:0]       fwd1;
    logic [1:0]       fwd2;
    logic             lu1;
    logic             lu2;
    ctrlState_e       state;
    ctrlState_e       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             dwait;
    logic             iwait;
    logic             waiting;
    logic             load_use;
    logic             timeout;
    logic             trap;

    fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd1 (
        .use_rs   (alu_src1_ex),
        .rs_addr  (rs1_addr_ex),
        .rd_ma    (rd0_addr_ma),
        .rd_wb    (rd0_addr_wb),
        .wr_en_ma (rd0_wr_en_ma),
        .wr_en_wb (rd0_wr_en_wb),
        .load_ma  (data_rd_en_ma),
        .fwd      (fwd1),
        .load_use (lu1)
    );

    fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd2 (
        .use_rs   (~alu_src2_ex),
        .rs_addr  (rs2_addr_ex),
        .rd_ma    (rd0_addr_ma),
        .rd_wb    (rd0_addr_wb),
        .wr_en_ma (rd0_wr_en_ma),
        .wr_en_wb (rd0_wr_en_wb),
        .load_ma  (data_rd_en_ma),
        .fwd      (fwd2),
        .load_use (lu2)
    );

    assign alu_src1  = (fwd1 != FWD_NONE) ? fwd1 : {1'b0, alu_src1_ex};
    assign alu_src2  = (fwd2 != FWD_NONE) ? fwd2 : {1'b0, alu_src2_ex};
    assign trap_addr = TRAP_VECTOR;

    // Watchdog counts consecutive memory-wait cycles, pulsing on the last allowed one
    always_comb begin
        dwait    = (data_rd_en_ma | data_wr_en_ma) & ~data_ready;
        iwait    = ~inst_ready;
        waiting  = dwait | iwait;
        load_use = lu1 | lu2;
        timeout  = clk_en & waiting & (state != TRAP) & (wait_cnt == CNT_LAST);
        trap     = clk_en & (exception | timeout);
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        if (clk_en) begin
            if (trap) begin
                state_nxt = TRAP;
            end else if (state == TRAP) begin
                state_nxt = RUN;
            end else if (dwait) begin
                state_nxt = DMEM_WAIT;
            end else if (iwait) begin
                state_nxt = IMEM_WAIT;
            end else begin
                state_nxt = RUN;
            end
            if (trap || state == TRAP || !waiting) begin
                wait_cnt_nxt = '0;
            end else begin
                wait_cnt_nxt = wait_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        if_id_clk_en = 1'b1;
        id_ex_clk_en = 1'b1;
        ex_ma_clk_en = 1'b1;
        ma_wb_clk_en = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_ma_flush  = 1'b0;
        pc_sel       = PC_NEXT;
        inst_rd_en   = 1'b1;
        mem_timeout  = 1'b0;
        if (rst) begin
            inst_rd_en = 1'b1;
        end else if (!clk_en) begin
            if_id_clk_en = 1'b0;
            id_ex_clk_en = 1'b0;
            ex_ma_clk_en = 1'b0;
            ma_wb_clk_en = 1'b0;
            inst_rd_en   = 1'b0;
        end else if (trap) begin
            pc_sel      = PC_TRAP;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_ma_flush = 1'b1;
            mem_timeout = timeout;
        end else if (dwait) begin
            if_id_clk_en = 1'b0;
            id_ex_clk_en = 1'b0;
            ex_ma_clk_en = 1'b0;
            ma_wb_clk_en = 1'b0;
        end else if (load_use) begin
            if_id_clk_en = 1'b0;
            id_ex_clk_en = 1'b0;
            ex_ma_flush  = 1'b1;
        end else if (iwait) begin
            if_id_clk_en = 1'b0;
            id_ex_flush  = 1'b1;
        end else if (branch_taken) begin
            pc_sel      = PC_JUMP;
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            epc      <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (trap) begin
                epc <= pc_ex;
            end
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic stalled;
    logic flushed;

    assign stalled = clk_en & ~trap & (dwait | load_use | iwait);
    assign flushed = if_id_flush | id_ex_flush | ex_ma_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stalled && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flushed && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
